// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract unit split into STAGES registered ripple-carry slices with a
// valid/ready handshake; the carry, remaining operand bits and finished sum bits move together.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned C = WIDTH / STAGES;

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned Lo  = k * C;       // result bits finished by earlier slices
        localparam int unsigned Rem = WIDTH - Lo;  // operand bits not yet added

        logic              v_i;
        logic              c_i;
        logic [Rem-1:0]    a_i;
        logic [Rem-1:0]    b_i;
        logic [C:0]        chunk;
        logic [Lo+C-1:0]   s_new;
        logic              v_q, v_d;
        logic              c_q, c_d;
        logic [Lo+C-1:0]   s_q, s_d;

        // Subtraction is folded in at the entry: invert B and the carry-in once.
        if (k == 0) begin : g_src
            assign v_i   = in_valid;
            assign c_i   = cin ^ sub;
            assign a_i   = a;
            assign b_i   = b ^ {WIDTH{sub}};
            assign s_new = chunk[C-1:0];
        end else begin : g_src
            assign v_i   = g_slice[k-1].v_q;
            assign c_i   = g_slice[k-1].c_q;
            assign a_i   = g_slice[k-1].g_fwd.a_q;
            assign b_i   = g_slice[k-1].g_fwd.b_q;
            assign s_new = {chunk[C-1:0], g_slice[k-1].s_q};
        end

        assign chunk = {1'b0, a_i[C-1:0]} + {1'b0, b_i[C-1:0]} + {{C{1'b0}}, c_i};

        always_comb begin
            v_d = v_q;
            c_d = c_q;
            s_d = s_q;
            if (!stall) begin
                v_d = v_i;
                if (v_i) begin
                    c_d = chunk[C];
                    s_d = s_new;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [Rem-C-1:0] a_q, a_d;
            logic [Rem-C-1:0] b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (!stall && v_i) begin
                    a_d = a_i[Rem-1:C];
                    b_d = b_i[Rem-1:C];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic ovf_q, ovf_d;
            logic zero_q, zero_d;

            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (!stall && v_i) begin
                    ovf_d  = (a_i[Rem-1] == b_i[Rem-1]) && (chunk[C-1] != a_i[Rem-1]);
                    zero_d = (s_new == '0);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign out_valid = g_slice[STAGES-1].v_q;
    assign sum       = g_slice[STAGES-1].s_q;
    assign cout      = g_slice[STAGES-1].c_q;
    assign overflow  = g_slice[STAGES-1].g_last.ovf_q;
    assign zero      = g_slice[STAGES-1].g_last.zero_q;

    // A full output register that is not being taken freezes the whole pipe.
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

endmodule
